// File: rtl/pc_fetch_stos_if.sv
// Decoder <-> fetch-unit bus: program counter, return-stack status and the
// decoder's control strobes.
//
// Transfer semantics: there is no valid/ready pair. Every control
// (ID_rst, skok_ID, skok_pc_ID, ID_push_pc, ID_pop_pc, jest_przerwanie,
// adres_skok_ID) is a level sampled on the rising clk edge and acted on only
// when ce=1. With ce=0 the controls are ignored and nothing changes. pc and
// the stack status outputs are valid at all times; empty/full reflect the
// current stack pointer so the decoder can guard push/pop in the same cycle.
interface pc_fetch_stos_if #(
  parameter int PC_WIDTH = 8,
  parameter int SP_WIDTH = 4
);
  // decoder -> fetch
  logic                ce;
  logic                ID_rst;
  logic                skok_ID;
  logic [PC_WIDTH-1:0] adres_skok_ID;
  logic                skok_pc_ID;
  logic                ID_push_pc;
  logic                ID_pop_pc;
  logic                jest_przerwanie;
  // fetch -> decoder / ROM
  logic [PC_WIDTH-1:0] pc;
  logic                stos_pc_empty;
  logic                stos_pc_full;
  logic                stos_pc_err;
  // debug: live stack pointer
  logic [SP_WIDTH-1:0] stos_sp;

  modport master (
    output ce, ID_rst, skok_ID, adres_skok_ID, skok_pc_ID,
           ID_push_pc, ID_pop_pc, jest_przerwanie,
    input  pc, stos_pc_empty, stos_pc_full, stos_pc_err, stos_sp
  );

  modport slave (
    input  ce, ID_rst, skok_ID, adres_skok_ID, skok_pc_ID,
           ID_push_pc, ID_pop_pc, jest_przerwanie,
    output pc, stos_pc_empty, stos_pc_full, stos_pc_err, stos_sp
  );
endinterface

// File: rtl/pc_fetch_stos.sv
// Program counter plus LIFO of return addresses. Handles sequential fetch,
// absolute jumps, returns from the stack top, calls/interrupt entry (push),
// and a sticky misuse flag that redirects fetch to the exception vector.
module pc_fetch_stos #(
  parameter int                    PC_WIDTH   = 8,
  parameter int                    STOS_DEPTH = 8,
  parameter logic [PC_WIDTH-1:0]   EXC_VEC    = PC_WIDTH'('h06)
) (
  input logic             clk,
  input logic             rst_n,
  pc_fetch_stos_if.slave  bus
);

  localparam int SPW  = $clog2(STOS_DEPTH + 1);
  localparam int IDXW = $clog2(STOS_DEPTH);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [SPW-1:0]      sp_q, sp_d;
  logic                err_q, err_d;
  logic [PC_WIDTH-1:0] mem [STOS_DEPTH];

  logic                empty, full, misuse, push_en;
  logic [IDXW-1:0]     wr_idx, rd_idx;
  logic [PC_WIDTH-1:0] top, ret;

  assign empty  = (sp_q == '0);
  assign full   = (sp_q == SPW'(STOS_DEPTH));
  assign wr_idx = IDXW'(sp_q);
  assign rd_idx = IDXW'(sp_q - SPW'(1));
  assign top    = mem[rd_idx];
  // Interrupt entry resumes the interrupted instruction; a CALL resumes after itself.
  assign ret    = bus.jest_przerwanie ? pc_q : pc_q + PC_WIDTH'(1);

  // Stack misuse: overflow, underflow, simultaneous push/pop, return from empty stack.
  assign misuse = (bus.ID_push_pc & full)
                | (bus.ID_pop_pc  & empty)
                | (bus.ID_push_pc & bus.ID_pop_pc)
                | (bus.skok_pc_ID & empty);

  // Next-state selection: ID_rst > misuse > jump/return > sequential.
  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    err_d   = err_q;
    push_en = 1'b0;
    if (bus.ce) begin
      if (bus.ID_rst) begin
        pc_d = '0;
        sp_d = '0;
      end else if (misuse) begin
        pc_d  = EXC_VEC;
        err_d = 1'b1;
      end else begin
        if (bus.skok_ID) begin
          pc_d = bus.skok_pc_ID ? top : bus.adres_skok_ID;
        end else begin
          pc_d = pc_q + PC_WIDTH'(1);
        end
        if (bus.ID_push_pc) begin
          sp_d    = sp_q + SPW'(1);
          push_en = 1'b1;
        end else if (bus.ID_pop_pc) begin
          sp_d = sp_q - SPW'(1);
        end
      end
    end
  end

  // PC, stack pointer and sticky error register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= '0;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Return-address storage; contents are meaningless after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (push_en && rst_n) begin
      mem[wr_idx] <= ret;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.stos_pc_empty = empty;
  assign bus.stos_pc_full  = full;
  assign bus.stos_pc_err   = err_q;
  assign bus.stos_sp       = sp_q;

endmodule

// File: tb/tb_pc_fetch_stos.sv
module tb_pc_fetch_stos;

  localparam int PCW = 8;
  localparam int SPW = 4;
  localparam int DEP = 8;
  localparam int W   = PCW + 3 + SPW;

  typedef struct {
    logic           ce, id_rst, skok, spc, push, pop, irq;
    logic [PCW-1:0] adres;
    logic [PCW-1:0] e_pc;
    logic           e_empty, e_full, e_err;
    logic [SPW-1:0] e_sp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  vec_t           tbl_a[$];
  vec_t           tbl_b[$];
  logic [W-1:0]   exp_q[$];
  logic [PCW-1:0] r;

  pc_fetch_stos_if #(.PC_WIDTH(PCW), .SP_WIDTH(SPW)) bus();

  pc_fetch_stos #(.PC_WIDTH(PCW), .STOS_DEPTH(DEP), .EXC_VEC(8'h06)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic ce, input logic id_rst, input logic skok,
                              input logic spc, input logic push, input logic pop,
                              input logic irq, input logic [PCW-1:0] adres,
                              input logic [PCW-1:0] e_pc, input int e_sp, input logic e_err);
    vec_t v;
    v.ce = ce; v.id_rst = id_rst; v.skok = skok; v.spc = spc;
    v.push = push; v.pop = pop; v.irq = irq; v.adres = adres;
    v.e_pc = e_pc; v.e_sp = SPW'(e_sp); v.e_err = e_err;
    v.e_empty = (e_sp == 0);
    v.e_full  = (e_sp == DEP);
    return v;
  endfunction

  // driver
  task automatic drive(input vec_t v);
    bus.ce = v.ce; bus.ID_rst = v.id_rst; bus.skok_ID = v.skok;
    bus.skok_pc_ID = v.spc; bus.ID_push_pc = v.push; bus.ID_pop_pc = v.pop;
    bus.jest_przerwanie = v.irq; bus.adres_skok_ID = v.adres;
  endtask

  task automatic push_exp(input logic [PCW-1:0] p, input int sp, input logic err);
    exp_q.push_back({p, (sp == 0), (sp == DEP), err, SPW'(sp)});
  endtask

  // scoreboard check: pop the oldest expectation and compare with the DUT now
  task automatic check_out(input string name);
    logic [W-1:0] e;
    logic [W-1:0] a;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard queue empty", name);
    end else begin
      e = exp_q.pop_front();
      a = {bus.pc, bus.stos_pc_empty, bus.stos_pc_full, bus.stos_pc_err, bus.stos_sp};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got pc=%h empty=%b full=%b err=%b sp=%0d, expected pc=%h empty=%b full=%b err=%b sp=%0d",
                 name, a[W-1 -: PCW], a[SPW+2], a[SPW+1], a[SPW], a[SPW-1:0],
                 e[W-1 -: PCW], e[SPW+2], e[SPW+1], e[SPW], e[SPW-1:0]);
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    @(negedge clk);
    drive(v);
    exp_q.push_back({v.e_pc, v.e_empty, v.e_full, v.e_err, v.e_sp});
    @(posedge clk);
    #1;
    check_out(name);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // ---------------- table A: normal operation and misuse ----------------
    for (int i = 1; i <= 5; i++) tbl_a.push_back(mk(1,0,0,0,0,0,0,8'h00, PCW'(i),0,0));
    tbl_a.push_back(mk(1,0,1,0,0,0,0,8'hFE, 8'hFE,0,0));
    tbl_a.push_back(mk(1,0,0,0,0,0,0,8'h00, 8'hFF,0,0));
    tbl_a.push_back(mk(1,0,0,0,0,0,0,8'h00, 8'h00,0,0));
    tbl_a.push_back(mk(1,0,0,0,0,0,0,8'h00, 8'h01,0,0));
    // CALL / RET
    tbl_a.push_back(mk(1,0,1,0,0,0,0,8'h10, 8'h10,0,0));
    tbl_a.push_back(mk(1,0,1,0,1,0,0,8'h40, 8'h40,1,0));
    tbl_a.push_back(mk(1,0,1,1,0,1,0,8'h00, 8'h11,0,0));
    // interrupt / RETI
    tbl_a.push_back(mk(1,0,1,0,0,0,0,8'h22, 8'h22,0,0));
    tbl_a.push_back(mk(1,0,1,0,1,0,1,8'h08, 8'h08,1,0));
    tbl_a.push_back(mk(1,0,0,0,0,0,0,8'h00, 8'h09,1,0));
    tbl_a.push_back(mk(1,0,1,1,0,1,0,8'h00, 8'h22,0,0));
    // fill the stack: returns 0x23, 0x51..0x57
    for (int i = 0; i < DEP; i++)
      tbl_a.push_back(mk(1,0,1,0,1,0,0,PCW'(8'h50 + i), PCW'(8'h50 + i),i+1,0));
    // overflow
    tbl_a.push_back(mk(1,0,1,0,1,0,0,8'h77, 8'h06,DEP,1));
    // unwind in LIFO order
    for (int k = 0; k < DEP - 1; k++)
      tbl_a.push_back(mk(1,0,1,1,0,1,0,8'h00, PCW'(8'h57 - k),DEP-1-k,1));
    tbl_a.push_back(mk(1,0,1,1,0,1,0,8'h00, 8'h23,0,1));
    // underflow: plain pop, then return from empty stack
    tbl_a.push_back(mk(1,0,0,0,0,1,0,8'h00, 8'h06,0,1));
    tbl_a.push_back(mk(1,0,0,0,0,0,0,8'h00, 8'h07,0,1));
    tbl_a.push_back(mk(1,0,1,1,0,1,0,8'h00, 8'h06,0,1));
    // random jump targets
    for (int i = 0; i < 4; i++) begin
      r = PCW'($urandom_range(0, 255));
      tbl_a.push_back(mk(1,0,1,0,0,0,0,r, r,0,1));
    end
    // push and pop together
    tbl_a.push_back(mk(1,0,1,0,0,0,0,8'h2F, 8'h2F,0,1));
    tbl_a.push_back(mk(1,0,1,0,1,0,0,8'h30, 8'h30,1,1));
    tbl_a.push_back(mk(1,0,0,0,1,1,0,8'h00, 8'h06,1,1));
    tbl_a.push_back(mk(1,0,1,1,0,1,0,8'h00, 8'h30,0,1));
    // ce=0 hold, then soft reset with sp=3
    tbl_a.push_back(mk(1,0,1,0,1,0,0,8'h60, 8'h60,1,1));
    tbl_a.push_back(mk(0,0,1,0,1,0,0,8'h99, 8'h60,1,1));
    tbl_a.push_back(mk(0,1,1,0,0,0,0,8'h99, 8'h60,1,1));
    tbl_a.push_back(mk(1,0,1,0,1,0,0,8'h61, 8'h61,2,1));
    tbl_a.push_back(mk(1,0,1,0,1,0,0,8'h62, 8'h62,3,1));
    tbl_a.push_back(mk(1,1,1,0,1,0,0,8'hAA, 8'h00,0,1));
    tbl_a.push_back(mk(1,0,0,0,0,0,0,8'h00, 8'h01,0,1));
    tbl_a.push_back(mk(1,0,1,0,1,0,0,8'h44, 8'h44,1,1));

    // ---------------- table B: interrupt into the last slot ----------------
    for (int i = 0; i < DEP - 1; i++)
      tbl_b.push_back(mk(1,0,1,0,1,0,0,PCW'(8'h70 + i), PCW'(8'h70 + i),i+1,0));
    tbl_b.push_back(mk(1,0,1,0,1,0,1,8'h08, 8'h08,DEP,0));
    tbl_b.push_back(mk(1,0,1,0,1,0,1,8'h08, 8'h06,DEP,1));
    tbl_b.push_back(mk(1,0,1,1,0,1,0,8'h00, 8'h76,DEP-1,1));
    tbl_b.push_back(mk(1,0,1,1,0,1,0,8'h00, 8'h76,DEP-2,1));
    tbl_b.push_back(mk(1,0,1,1,0,1,0,8'h00, 8'h75,DEP-3,1));

    // ---------------- reset ----------------
    rst_n = 1'b0;
    drive(mk(0,0,0,0,0,0,0,8'h00, 8'h00,0,0));
    repeat (3) @(posedge clk);
    #1;
    push_exp(8'h00, 0, 1'b0);
    check_out("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl_a[i]) run_vec(tbl_a[i], $sformatf("A%0d", i));

    // ---------------- asynchronous reset in the middle of a push ----------------
    @(negedge clk);
    drive(mk(1,0,1,0,1,0,0,8'h33, 8'h00,0,0));
    #2;
    rst_n = 1'b0;
    #1;
    push_exp(8'h00, 0, 1'b0);
    check_out("async_rst");
    @(posedge clk);
    #1;
    push_exp(8'h00, 0, 1'b0);
    check_out("rst_hold_edge");
    @(negedge clk);
    drive(mk(0,0,0,0,0,0,0,8'h00, 8'h00,0,0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_exp(8'h00, 0, 1'b0);
    check_out("rst_release_ce0");

    foreach (tbl_b[i]) run_vec(tbl_b[i], $sformatf("B%0d", i));

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
